// File: rtl/wom_write_arbiter_if.sv
// AHB-Lite write-side bus bundle for the write-only-memory arbiter.
// The master drives the address/data phase signals; the slave answers with ready/response.
interface wom_write_arbiter_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP
  );
endinterface

// File: rtl/wom_write_arbiter.sv
// Merges zero-wait-state AHB-Lite writes with a background whole-memory fill engine
// onto one registered memory write port; AHB data phases always win a collision.
module wom_write_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  wom_write_arbiter_if.slave    ahb,
  input  logic                  fill_start,
  input  logic                  fill_abort,
  input  logic [DW-1:0]         fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [AW-1:0]         addr,
  output logic [DW-1:0]         data,
  output logic                  we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            dphase_q;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   cnt_q;
  logic [DW-1:0]   pat_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            we_q;
  logic            busy_q;
  logic            done_q;
  logic            accept_s;
  logic            unused_bits;

  assign accept_s = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & ahb.HWRITE;

  // Address bits outside the word index and data bits above DW are intentionally ignored.
  assign unused_bits = ^{ahb.HADDR[31:AW+2], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:DW]};

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign addr      = addr_q;
  assign data      = data_q;
  assign we        = we_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

  // AHB pipeline, fill FSM and the registered write port, all in one sequential block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      dphase_q <= 1'b0;
      idx_q    <= {AW{1'b0}};
      cnt_q    <= {AW{1'b0}};
      pat_q    <= {DW{1'b0}};
      addr_q   <= {AW{1'b0}};
      data_q   <= {DW{1'b0}};
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      dphase_q <= accept_s;
      if (accept_s) begin
        idx_q <= ahb.HADDR[AW+1:2];
      end
      we_q   <= 1'b0;
      done_q <= 1'b0;

      if (dphase_q) begin
        addr_q <= idx_q;
        data_q <= ahb.HWDATA[DW-1:0];
        we_q   <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          // A coincident abort is meaningless in IDLE, so start takes effect.
          if (fill_start) begin
            pat_q   <= fill_value;
            cnt_q   <= {AW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (fill_abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!dphase_q) begin
            addr_q <= cnt_q;
            data_q <= pat_q;
            we_q   <= 1'b1;
            cnt_q  <= cnt_q + {{(AW-1){1'b0}}, 1'b1};
            if (&cnt_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wom_write_arbiter.sv
// Directed self-checking bench for wom_write_arbiter: AHB writes, fills, collisions,
// abort and asynchronous reset, with hand-derived expected values.
module tb_wom_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fill_start;
  logic        fill_abort;
  logic [15:0] fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [9:0]  addr;
  logic [15:0] data;
  logic        we;

  int n_cmp = 0;
  int n_err = 0;

  wom_write_arbiter_if bus ();

  wom_write_arbiter #(.AW(10), .DW(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ahb        (bus.slave),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .addr       (addr),
    .data       (data),
    .we         (we)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ahb_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HREADY = 1'b1;
  endtask

  task automatic ahb_addr(input logic [31:0] a);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HADDR  = a;
    bus.HREADY = 1'b1;
  endtask

  // Packs {busy, done, we, addr, data}; addr/data are zeroed when no write is expected.
  function automatic logic [31:0] pack(input logic b, input logic d, input logic w,
                                       input logic [9:0] a, input logic [15:0] v);
    return {3'b000, b, d, w, (w ? a : 10'h000), (w ? v : 16'h0000)};
  endfunction

  // Full fill; with collide, an AHB write to index 0x200 lands while the counter is 0x100.
  task automatic fill_run(input logic [15:0] pat, input bit collide);
    int          done_c;
    int          k;
    logic        ew;
    logic [9:0]  ea;
    logic [15:0] ed;
    done_c     = collide ? 1026 : 1025;
    fill_start = 1'b1;
    fill_value = pat;
    step();
    fill_start = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      ew = 1'b0;
      ea = 10'h000;
      ed = 16'h0000;
      if (collide && c == 258) begin
        ew = 1'b1;
        ea = 10'h200;
        ed = 16'hBEEF;
      end else begin
        k = (collide && c >= 259) ? c - 3 : c - 2;
        if (c >= 2 && k >= 0 && k <= 1023) begin
          ew = 1'b1;
          ea = k[9:0];
          ed = pat;
        end
      end
      chk(collide ? "fill_collide" : "fill_plain",
          pack(fill_busy, fill_done, we, addr, data),
          pack(c <= done_c, c == done_c, ew, ea, ed));
      ahb_idle();
      fill_start = 1'b0;
      if (collide && c == 256) ahb_addr(32'h0000_0800);
      if (collide && c == 257) bus.HWDATA = 32'h0000_BEEF;
      if (c == 500) begin
        fill_start = 1'b1;
        fill_value = 16'hFFFF;
      end
      step();
    end
  endtask

  initial begin
    logic [31:0] waddr [4];
    logic [31:0] wdata [4];
    RST        = 1'b1;
    fill_start = 1'b0;
    fill_abort = 1'b0;
    fill_value = 16'h0000;
    bus.HWDATA = 32'h0;
    ahb_idle();
    step();
    step();
    chk("reset_outs", pack(fill_busy, fill_done, we, addr, data), 32'h0);
    chk("reset_raw", {5'b0, addr, data, we}, 32'h0);
    chk("hreadyout", {30'b0, bus.HREADYOUT, bus.HRESP}, 32'h2);
    RST = 1'b0;
    step();

    // Single write: HADDR 0x104 -> index 0x041, visible two cycles after the address phase.
    ahb_addr(32'h0000_0104);
    step();
    ahb_idle();
    bus.HWDATA = 32'h1234_ABCD;
    chk("single_dphase_we", {31'b0, we}, 32'h0);
    step();
    chk("single_write", {5'b0, addr, data, we}, {5'b0, 10'h041, 16'hABCD, 1'b1});
    step();
    chk("single_after", {5'b0, addr, data, we}, {5'b0, 10'h041, 16'hABCD, 1'b0});

    // Four back-to-back writes, zero wait states.
    waddr[0] = 32'h0000_0028; wdata[0] = 32'hFFFF_1111;
    waddr[1] = 32'h0000_002C; wdata[1] = 32'h0000_2222;
    waddr[2] = 32'h0000_0030; wdata[2] = 32'h1234_3333;
    waddr[3] = 32'h0000_0FFC; wdata[3] = 32'hAAAA_4444;
    for (int i = 0; i <= 5; i++) begin
      if (i < 4) ahb_addr(waddr[i]);
      else ahb_idle();
      if (i >= 1 && i <= 4) bus.HWDATA = wdata[i-1];
      step();
      if (i >= 1 && i <= 4) begin
        chk("b2b_write", {5'b0, addr, data, we}, {5'b0, waddr[i-1][11:2], wdata[i-1][15:0], 1'b1});
        chk("b2b_hready", {31'b0, bus.HREADYOUT}, 32'h1);
      end else if (i == 5) begin
        chk("b2b_end", {31'b0, we}, 32'h0);
      end else begin
        chk("b2b_first", {31'b0, we}, 32'h0);
      end
    end

    // Reads, BUSY, deselected and not-ready transfers must not write.
    for (int v = 0; v < 4; v++) begin
      ahb_addr(32'h0000_0100);
      case (v)
        0: bus.HWRITE = 1'b0;
        1: bus.HTRANS = 2'b01;
        2: bus.HSEL   = 1'b0;
        default: bus.HREADY = 1'b0;
      endcase
      step();
      ahb_idle();
      bus.HWDATA = 32'h0000_DEAD;
      step();
      step();
      chk("ignored_xfer", {31'b0, we}, 32'h0);
    end

    fill_run(16'h5A5A, 1'b0);
    fill_run(16'h1111, 1'b1);

    // Coincident start+abort starts the fill; abort at counter 0x080 stops it cleanly.
    fill_start = 1'b1;
    fill_abort = 1'b1;
    fill_value = 16'h3C3C;
    step();
    fill_start = 1'b0;
    fill_abort = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      chk("abort_seq", pack(fill_busy, fill_done, we, addr, data),
          pack(c <= 'h81, 1'b0, (c >= 2 && c <= 'h81), 10'(c - 2), 16'h3C3C));
      fill_abort = (c == 'h81);
      step();
    end
    chk("abort_last_addr", {22'b0, addr}, 32'h7F);

    // Asynchronous reset during a fill and a pending data phase.
    fill_start = 1'b1;
    fill_value = 16'h7777;
    step();
    fill_start = 1'b0;
    repeat (8) step();
    ahb_addr(32'h0000_0040);
    step();
    ahb_idle();
    bus.HWDATA = 32'h0000_9999;
    #2 RST = 1'b1;
    #1;
    chk("rst_async", {2'b0, fill_busy, fill_done, addr, data, we}, 32'h0);
    step();
    step();
    RST = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("rst_quiet", {29'b0, fill_busy, fill_done, we}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wom_write_arbiter.md
WOM_WRITE_ARBITER -- requirements
Module: wom_write_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning memory word-address width (1K words).
REQ-002 SHALL have parameter DW, default 16, meaning memory data width.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port HSEL  in  1  AHB-Lite slave select.
REQ-006 SHALL have port HADDR  in  32  AHB address; word index = HADDR[AW+1:2].
REQ-007 SHALL have port HTRANS  in  2  AHB transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
REQ-008 SHALL have port HWRITE  in  1  AHB write strobe.
REQ-009 SHALL have port HWDATA  in  32  AHB write data; only HWDATA[DW-1:0] is used.
REQ-010 SHALL have port HREADY  in  1  AHB bus ready.
REQ-011 SHALL have port HREADYOUT  out  1  slave ready; constant 1.
REQ-012 SHALL have port HRESP  out  1  slave response; constant 0 (OKAY).
REQ-013 SHALL have port fill_start  in  1  one-cycle request to fill the whole memory.
REQ-014 SHALL have port fill_abort  in  1  one-cycle request to stop a running fill.
REQ-015 SHALL have port fill_value  in  DW  fill pattern, sampled on accepted fill_start.
REQ-016 SHALL have port fill_busy  out  1  fill in progress.
REQ-017 SHALL have port fill_done  out  1  one-cycle pulse on fill completion.
REQ-018 SHALL have port addr  out  AW  registered memory write address.
REQ-019 SHALL have port data  out  DW  registered memory write data.
REQ-020 SHALL have port we  out  1  registered memory write enable.

Function
REQ-021 SHALL accept an AHB write address phase when HSEL & HREADY & HTRANS[1] & HWRITE, latching the word index and setting a data-phase flag.
REQ-022 SHALL ignore AHB reads and IDLE/BUSY transfers; no memory write results from them.
REQ-023 SHALL, in the cycle after acceptance (data phase), register addr=latched index, data=HWDATA[DW-1:0], we=1; the write is visible on the outputs one cycle after the data phase.
REQ-024 SHALL support back-to-back AHB writes, one memory write per cycle, with zero wait states.
REQ-025 SHALL implement FSM states IDLE, FILL, DONE.
REQ-026 SHALL, in IDLE on fill_start, latch fill_value, clear the fill counter to 0, and go to FILL; fill_busy=1 from the next cycle.
REQ-027 SHALL, in FILL, in each cycle with no AHB data phase, register addr=counter, data=latched pattern, we=1, and increment the counter.
REQ-028 SHALL give AHB data phases absolute priority; in a collision cycle the AHB write is issued and the fill counter holds.
REQ-029 SHALL, after issuing the fill write at counter 2^AW-1, go to DONE; DONE pulses fill_done for exactly one cycle, clears fill_busy, and returns to IDLE.
REQ-030 SHALL ignore fill_start while in FILL or DONE.
REQ-031 SHALL, on fill_abort in FILL, return to IDLE next cycle with no further fill writes and no fill_done pulse; fill_abort in IDLE is ignored.
REQ-032 SHALL, when fill_start and fill_abort coincide in IDLE, start the fill.
REQ-033 SHALL drive we=0 in any cycle with neither an AHB data phase nor a fill write; addr and data hold their last values.

Reset
REQ-034 SHALL, while RST=1, force addr=0, data=0, we=0, fill_busy=0, fill_done=0, state=IDLE, fill counter=0, and data-phase flag=0, independent of CLK.
REQ-035 SHALL abort a fill or a pending AHB data phase on reset; no write is issued for it after RST deasserts.

Verification
REQ-036 SHALL cover: AHB write to HADDR=0x0000_0104 with HWDATA=0x1234_ABCD -> addr=0x041, data=0xABCD, we=1 for one cycle, two cycles after the address phase.
REQ-037 SHALL cover: four back-to-back AHB writes -> four consecutive we=1 cycles in order; HREADYOUT=1 throughout.
REQ-038 SHALL cover: fill_start with fill_value=0x5A5A and no AHB traffic -> 1024 writes to addr 0..1023, then fill_done high for one cycle 1025 cycles after fill_start.
REQ-039 SHALL cover: AHB write to index 0x200 while the fill counter is at 0x100 -> AHB write issued; fill resumes at 0x100; the fill completes one cycle later than in REQ-038.
REQ-040 SHALL cover: fill_abort at counter 0x080 -> last fill addr=0x07F or 0x080 per REQ-031 timing, fill_busy=0, no fill_done.
REQ-041 SHALL cover: RST asserted mid-fill and mid-data-phase -> all outputs 0 immediately; no we after release until a new request.
